// File: rtl/axi_rd_pkg.sv
// Shared definitions for the instruction-fetch AXI read responder.
//   AXI_DW      data width of one R beat
//   LEN_W       width of arlen (beats minus one)
//   LINE_BEATS  beats in a cache-line refill; also sizes the beat counter
//   LAT_W       width of the first-beat latency counter (LATENCY 0..15)
//   rd_state_e  responder FSM states
package axi_rd_pkg;

    localparam int AXI_DW     = 32;
    localparam int LEN_W      = 4;
    localparam int LINE_BEATS = 16;
    localparam int LAT_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } rd_state_e;

endpackage

// File: rtl/axi_burst_rd_slave_if.sv
// AR/R channel bundle between the fetch unit (master) and the ROM responder (slave).
//   araddr/arlen/arvalid -> request, arready <- accept
//   rdata/rvalid/rlast   <- beats,   rready  -> consume
interface axi_burst_rd_slave_if;
    import axi_rd_pkg::*;

    logic [31:0]       araddr;
    logic [LEN_W-1:0]  arlen;
    logic              arvalid;
    logic              arready;
    logic [AXI_DW-1:0] rdata;
    logic              rvalid;
    logic              rlast;
    logic              rready;

    modport master (
        output araddr, arlen, arvalid, rready,
        input  arready, rdata, rvalid, rlast
    );

    modport slave (
        input  araddr, arlen, arvalid, rready,
        output arready, rdata, rvalid, rlast
    );

endinterface

// File: rtl/rd_rom.sv
// Word-addressed read-only memory with an asynchronous read port.
//   addr  in   MEM_AW  word address
//   dout  out  32      word at addr, same cycle
// Every word is filled with 32'h1000_0000 + index at time zero, giving a
// recognisable, address-tagged pattern. INIT_FILE names the image this ROM
// stands in for; the contents are generated in place.
module rd_rom
    import axi_rd_pkg::*;
#(
    parameter int    MEM_AW    = 10,
    parameter string INIT_FILE = "inst.hex"
) (
    input  logic [MEM_AW-1:0] addr,
    output logic [AXI_DW-1:0] dout
);

    localparam int                DEPTH     = 2 ** MEM_AW;
    localparam logic [AXI_DW-1:0] FILL_BASE = 32'h1000_0000;

    // NOTE: ROM storage has no reset; its contents are fixed at load time and
    // a reset would only turn the array into a huge bank of flops.
    logic [AXI_DW-1:0] r_mem [DEPTH];

    function automatic logic load_rom();
        for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] = FILL_BASE + AXI_DW'(i);
        end
        return 1'b1;
    endfunction

    // Loading happens as a side effect of this initialiser at time zero.
    logic r_loaded = load_rom();

    assign dout = r_loaded ? r_mem[addr] : '0;

endmodule

// File: rtl/axi_burst_rd_slave.sv
// Fetch-side AXI read responder: accepts one AR request and returns arlen+1
// incrementing 32-bit beats from a word-addressed ROM.
//   clk      in   posedge clock
//   resetn   in   asynchronous active-low reset
//   bus      slave modport: araddr/arlen/arvalid/arready, rdata/rvalid/rlast/rready
// Parameters: MEM_AW (ROM word-address width), LATENCY (0..15 idle cycles
// before the first beat), INIT_FILE (ROM image).
// All bus outputs are registered. The ROM is read at the *next* index so the
// registered rdata always equals rom[idx] while a beat is presented.
module axi_burst_rd_slave
    import axi_rd_pkg::*;
#(
    parameter int    MEM_AW    = 10,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = "inst.hex"
) (
    input logic                 clk,
    input logic                 resetn,
    axi_burst_rd_slave_if.slave bus
);

    localparam int               BEAT_W    = $clog2(LINE_BEATS);
    localparam logic [LAT_W-1:0] WAIT_LAST = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    rd_state_e         r_state,  w_state_nxt;
    logic [MEM_AW-1:0] r_idx,    w_idx_nxt;
    logic [LEN_W-1:0]  r_len,    w_len_nxt;
    logic [BEAT_W-1:0] r_beat,   w_beat_nxt;
    logic [LAT_W-1:0]  r_wcnt,   w_wcnt_nxt;
    logic              r_arready;
    logic              r_rvalid;
    logic              r_rlast;
    logic [AXI_DW-1:0] r_rdata;
    logic [AXI_DW-1:0] w_rom_dout;
    logic              w_accept;
    logic              w_beat_done;

    rd_rom #(
        .MEM_AW    (MEM_AW),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .addr (w_idx_nxt),
        .dout (w_rom_dout)
    );

    // r_rvalid is high exactly while in BURST, so it doubles as the state test.
    assign w_accept    = (r_state == IDLE) && bus.arvalid && r_arready;
    assign w_beat_done = r_rvalid && bus.rready;

    // NOTE: every variable gets its hold value before the case statement, so
    // no path through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_len_nxt   = r_len;
        w_beat_nxt  = r_beat;
        w_wcnt_nxt  = r_wcnt;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    // Byte address -> word index; upper bits alias by truncation.
                    w_idx_nxt   = MEM_AW'(bus.araddr >> 2);
                    w_len_nxt   = bus.arlen;
                    w_beat_nxt  = '0;
                    w_wcnt_nxt  = '0;
                    w_state_nxt = (LATENCY > 0) ? WAIT : BURST;
                end
            end
            WAIT: begin
                if (r_wcnt == WAIT_LAST) begin
                    w_state_nxt = BURST;
                end else begin
                    w_wcnt_nxt = r_wcnt + LAT_W'(1);
                end
            end
            BURST: begin
                if (w_beat_done) begin
                    // Index wraps silently at the top of the ROM.
                    w_idx_nxt  = r_idx + MEM_AW'(1);
                    w_beat_nxt = r_beat + BEAT_W'(1);
                    if (r_rlast) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_idx     <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_wcnt    <= '0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_idx     <= w_idx_nxt;
            r_len     <= w_len_nxt;
            r_beat    <= w_beat_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_arready <= (w_state_nxt == IDLE);
            r_rvalid  <= (w_state_nxt == BURST);
            r_rlast   <= (w_state_nxt == BURST) && (w_beat_nxt == w_len_nxt);
            r_rdata   <= (w_state_nxt == BURST) ? w_rom_dout : '0;
        end
    end

    assign bus.arready = r_arready;
    assign bus.rvalid  = r_rvalid;
    assign bus.rlast   = r_rlast;
    assign bus.rdata   = r_rdata;

endmodule

// File: tb/tb_axi_burst_rd_slave.sv
// Bench for axi_burst_rd_slave: one instance with LATENCY=2, one with LATENCY=0,
// both with the default ROM fill (word n = 32'h1000_0000 + n). Expected beats,
// latency and handshake behaviour are computed from the burst rules directly.
module tb_axi_burst_rd_slave;
    import axi_rd_pkg::*;

    localparam int MEM_AW = 10;
    localparam int DEPTH  = 2 ** MEM_AW;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Shared stimulus; sel routes it to the LATENCY=2 (0) or LATENCY=0 (1) instance.
    logic        sel;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic        arvalid;
    logic        rready;

    axi_burst_rd_slave_if bus2 ();
    axi_burst_rd_slave_if bus0 ();

    assign bus2.araddr  = araddr;
    assign bus2.arlen   = arlen;
    assign bus2.arvalid = arvalid && !sel;
    assign bus2.rready  = sel ? 1'b1 : rready;
    assign bus0.araddr  = araddr;
    assign bus0.arlen   = arlen;
    assign bus0.arvalid = arvalid && sel;
    assign bus0.rready  = sel ? rready : 1'b1;

    logic        mon_arready, mon_rvalid, mon_rlast;
    logic [31:0] mon_rdata;
    assign mon_arready = sel ? bus0.arready : bus2.arready;
    assign mon_rvalid  = sel ? bus0.rvalid  : bus2.rvalid;
    assign mon_rlast   = sel ? bus0.rlast   : bus2.rlast;
    assign mon_rdata   = sel ? bus0.rdata   : bus2.rdata;

    axi_burst_rd_slave #(.MEM_AW(MEM_AW), .LATENCY(2), .INIT_FILE("")) dut_lat2 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus2)
    );

    axi_burst_rd_slave #(.MEM_AW(MEM_AW), .LATENCY(0), .INIT_FILE("")) dut_lat0 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0)
    );

    // Reference: beat k of a burst at byte address addr.
    function automatic logic [31:0] exp_word(input logic [31:0] addr, input int k);
        int unsigned w;
        w = ((addr >> 2) + 32'(k)) % DEPTH;
        return 32'h1000_0000 + w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and consume its beats. Entered and left at a negedge.
    // stall_at/stall_n: hold rready low for stall_n cycles on beat stall_at.
    // rnd: random rready. hold_next: keep arvalid high with the next request.
    task automatic burst(input logic [31:0] addr, input int len,
                         input int stall_at, input int stall_n, input bit rnd,
                         input bit hold_next, input logic [31:0] n_addr, input int n_len,
                         output int acc_wait);
        int k, cyc, first, stall_left, shown, lat;
        bit accepted, done;
        lat      = sel ? 0 : 2;
        araddr   = addr;
        arlen    = 4'(len);
        arvalid  = 1'b1;
        rready   = 1'b1;
        acc_wait = 0;
        accepted = 1'b0;
        while (!accepted && acc_wait < 64) begin
            if (mon_arready) accepted = 1'b1;
            else begin
                @(negedge clk);
                acc_wait++;
            end
        end
        if (!accepted) begin
            check("accept_timeout", 32'(acc_wait), 0);
            arvalid = 1'b0;
            return;
        end
        @(negedge clk);
        if (hold_next) begin
            araddr = n_addr;
            arlen  = 4'(n_len);
        end else begin
            arvalid = 1'b0;
        end
        k = 0; cyc = 1; first = -1; stall_left = stall_n; shown = 0; done = 1'b0;
        while (!done && cyc < 256) begin
            check("arready_busy", 32'(mon_arready), 0);
            if (mon_rvalid) begin
                if (first < 0) begin
                    first = cyc;
                    check("first_beat_latency", 32'(first), 32'(lat + 1));
                end
                check("rdata", mon_rdata, exp_word(addr, k));
                check("rlast", 32'(mon_rlast), 32'(k == len));
                if (k == stall_at) shown++;
                if (k == stall_at && stall_left > 0) begin
                    rready = 1'b0;
                    stall_left--;
                end else if (rnd) begin
                    rready = ($urandom_range(3) != 0);
                end else begin
                    rready = 1'b1;
                end
                if (rready) begin
                    done = (k == len);
                    k++;
                end
            end else begin
                check("rlast_without_rvalid", 32'(mon_rlast), 0);
                rready = rnd ? 1'($urandom_range(1)) : 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            check("burst_timeout_beats", 32'(k), 32'(len + 1));
        end else begin
            check("rvalid_after_last", 32'(mon_rvalid), 0);
            check("rlast_after_last", 32'(mon_rlast), 0);
            check("arready_after_last", 32'(mon_arready), 1);
        end
        if (stall_at >= 0 && stall_at <= len)
            check("stall_hold_cycles", 32'(shown), 32'(stall_n + 1));
        rready = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        int          w;
        int          seen;
        logic [31:0] a;
        int          l;

        sel = 1'b0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b1;
        resetn = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values on both instances.
        check("reset_arready", 32'(bus2.arready), 0);
        check("reset_rvalid",  32'(bus2.rvalid), 0);
        check("reset_rlast",   32'(bus2.rlast), 0);
        check("reset_rdata",   bus2.rdata, 0);
        check("reset_arready_lat0", 32'(bus0.arready), 0);
        check("reset_rvalid_lat0",  32'(bus0.rvalid), 0);

        // arready rises on the first edge after release, not before.
        resetn = 1'b1;
        #1;
        check("arready_at_release", 32'(mon_arready), 0);
        @(negedge clk);
        check("arready_first_edge", 32'(mon_arready), 1);

        // Line refill, single beat, backpressure, wrap at ROM top, aliasing.
        burst(32'h40, 15, -1, 0, 1'b0, 1'b0, 0, 0, w);
        burst(32'h104, 0, -1, 0, 1'b0, 1'b0, 0, 0, w);
        burst(32'h40, 15, 2, 3, 1'b0, 1'b0, 0, 0, w);
        burst(32'hFF8, 3, -1, 0, 1'b0, 1'b0, 0, 0, w);
        burst(32'hFFFF_F004, 1, -1, 0, 1'b0, 1'b0, 0, 0, w);

        // Reset while the 7th beat is on the bus.
        araddr = 32'h40; arlen = 4'd15; arvalid = 1'b1; rready = 1'b1;
        w = 0;
        while (!mon_arready && w < 64) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        seen = 0;
        w = 0;
        while (seen < 7 && w < 64) begin
            if (mon_rvalid) seen++;
            if (seen < 7) begin
                @(negedge clk);
                w++;
            end
        end
        check("beat7_before_reset", mon_rdata, exp_word(32'h40, 6));
        resetn = 1'b0;
        #1;
        check("midreset_rvalid",  32'(mon_rvalid), 0);
        check("midreset_rlast",   32'(mon_rlast), 0);
        check("midreset_arready", 32'(mon_arready), 0);
        check("midreset_rdata",   mon_rdata, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        burst(32'h0, 0, -1, 0, 1'b0, 1'b0, 0, 0, w);

        // Back-to-back with arvalid held through the first burst.
        burst(32'h40, 15, -1, 0, 1'b0, 1'b1, 32'h200, 2, w);
        burst(32'h200, 2, -1, 0, 1'b0, 1'b0, 0, 0, w);
        check("b2b_accept_wait", 32'(w), 0);

        // Random requests and random rready.
        repeat (8) begin
            a = $urandom;
            l = $urandom_range(15);
            burst(a, l, -1, 0, 1'b1, 1'b0, 0, 0, w);
        end

        // LATENCY=0 instance.
        sel = 1'b1;
        @(negedge clk);
        burst(32'h0, 0, -1, 0, 1'b0, 1'b0, 0, 0, w);
        burst(32'h40, 15, -1, 0, 1'b0, 1'b1, 32'hFFC, 3, w);
        burst(32'hFFC, 3, -1, 0, 1'b0, 1'b0, 0, 0, w);
        check("b2b_accept_wait_lat0", 32'(w), 0);
        repeat (6) begin
            a = $urandom;
            l = $urandom_range(15);
            burst(a, l, -1, 0, 1'b1, 1'b0, 0, 0, w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
